// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of a single sram_controller.
// It latches the granted request, pulses mem_en for one cycle, and holds rw/address/data
// until the matching finish strobe arrives. It then returns a one-cycle ack (or err on
// watchdog expiry) to the owning port. A post-reset FLUSH drains the unreset controller.
module sram_arbiter #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15,
    parameter int FLUSH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_read_finish,
    input  logic              mem_write_finish
);

    // One counter serves both the FLUSH drain and the WAIT watchdog.
    localparam int CNT_MAX = (TIMEOUT > FLUSH) ? TIMEOUT : FLUSH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FLUSH - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               err0_q, err0_d;
    logic               err1_q, err1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic               busy_q, busy_d;
    logic               win;
    logic               finish;

    // Next-state and registered-output logic; every output is computed here and flopped.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        win          = 1'b0;
        finish       = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                // Requests are ignored while the controller's residual sequence drains.
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time is served.
                    win          = (req0 && req1) ? ~last_grant_q : req1;
                    grant_d      = win;
                    last_grant_d = win;
                    mem_rw_d     = win ? rw1    : rw0;
                    mem_addr_d   = win ? addr1  : addr0;
                    mem_wdata_d  = win ? wdata1 : wdata0;
                    mem_en_d     = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Only the strobe matching the latched direction completes the access.
                finish = mem_rw_q ? mem_write_finish : mem_read_finish;
                if (finish) begin
                    state_d = ST_DONE;
                    if (grant_q) begin
                        ack1_d = 1'b1;
                        if (!mem_rw_q) begin
                            rdata1_d = mem_rdata;
                        end
                    end else begin
                        ack0_d = 1'b1;
                        if (!mem_rw_q) begin
                            rdata0_d = mem_rdata;
                        end
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_DONE;
                    if (grant_q) begin
                        err1_d = 1'b1;
                    end else begin
                        err0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access and restarts the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized accesses against a behavioural controller
// and a transaction-level reference model of the arbiter.
module tb_sram_arbiter;

    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;
    localparam int FLUSH   = 8;

    logic              clk;
    logic              rst;
    logic              req0, rw0, req1, rw1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy, mem_en, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_read_finish, mem_write_finish;

    int n_pass  = 0;
    int n_total = 0;

    // Controller model state and knobs
    int                ctl_cnt = 0;
    logic              ctl_rw;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_wdata;
    bit                suppress     = 1'b0;
    bit                inject_wrong = 1'b0;
    logic [DATA_W-1:0] sram    [int unsigned];
    logic [DATA_W-1:0] ref_mem [int unsigned];
    logic [DATA_W-1:0] exp_rdata [2];

    sram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .FLUSH  (FLUSH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (req0),
        .rw0             (rw0),
        .addr0           (addr0),
        .wdata0          (wdata0),
        .req1            (req1),
        .rw1             (rw1),
        .addr1           (addr1),
        .wdata1          (wdata1),
        .ack0            (ack0),
        .ack1            (ack1),
        .err0            (err0),
        .err1            (err1),
        .rdata0          (rdata0),
        .rdata1          (rdata1),
        .busy            (busy),
        .mem_en          (mem_en),
        .mem_rw          (mem_rw),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_read_finish (mem_read_finish),
        .mem_write_finish(mem_write_finish)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Contents of a never-written location
    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'h5A5A ^ {13'd0, a[18:16]};
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(32'(a))) return ref_mem[32'(a)];
        return dflt(a);
    endfunction

    // Controller model: END strobe 5 cycles after the en cycle; not affected by rst.
    initial begin
        mem_read_finish  = 1'b0;
        mem_write_finish = 1'b0;
        mem_rdata        = '0;
        forever begin
            @(negedge clk);
            mem_read_finish  = 1'b0;
            mem_write_finish = 1'b0;
            if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (inject_wrong && !ctl_rw && ctl_cnt == 3) mem_write_finish = 1'b1;
                if (ctl_cnt == 0 && !suppress) begin
                    if (ctl_rw) begin
                        sram[32'(ctl_addr)] = ctl_wdata;
                        mem_write_finish = 1'b1;
                    end else begin
                        mem_rdata = sram.exists(32'(ctl_addr)) ? sram[32'(ctl_addr)] : dflt(ctl_addr);
                        mem_read_finish = 1'b1;
                    end
                end
            end
            if (mem_en === 1'b1) begin
                ctl_cnt   = 5;
                ctl_rw    = mem_rw;
                ctl_addr  = mem_addr;
                ctl_wdata = mem_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete access from an idle arbiter, checked against the reference model.
    task automatic do_access(input int port, input logic rw, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input bit exp_err, input string tag);
        int   done_k, en_cnt, hold_bad, exp_lat, w;
        logic g_ack0, g_ack1, g_err0, g_err1;
        done_k = 0; en_cnt = 0; hold_bad = 0; w = 0;
        g_ack0 = 1'b0; g_ack1 = 1'b0; g_err0 = 1'b0; g_err1 = 1'b0;
        exp_lat = exp_err ? TIMEOUT + 3 : 7;
        @(negedge clk);
        while (busy !== 1'b0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        if (port == 0) begin
            req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d;
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mem_en === 1'b1) en_cnt++;
            if (k <= 6 && (mem_rw !== rw || mem_addr !== a || mem_wdata !== d)) hold_bad++;
            if (ack0 === 1'b1 || ack1 === 1'b1 || err0 === 1'b1 || err1 === 1'b1) begin
                g_ack0 = ack0; g_ack1 = ack1; g_err0 = err0; g_err1 = err1;
                done_k = k;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!exp_err) begin
            if (rw) ref_mem[32'(a)] = d;
            else exp_rdata[port] = ref_rd(a);
        end
        check({tag, "_lat"},  32'(done_k), 32'(exp_lat));
        check({tag, "_ack"},  32'(port == 0 ? g_ack0 : g_ack1), 32'(!exp_err));
        check({tag, "_err"},  32'(port == 0 ? g_err0 : g_err1), 32'(exp_err));
        check({tag, "_other"}, 32'(port == 0 ? (g_ack1 | g_err1) : (g_ack0 | g_err0)), 32'd0);
        check({tag, "_en"},   32'(en_cnt), 32'd1);
        check({tag, "_hold"}, 32'(hold_bad), 32'd0);
        check({tag, "_rd0"},  32'(rdata0), 32'(exp_rdata[0]));
        check({tag, "_rd1"},  32'(rdata1), 32'(exp_rdata[1]));
    endtask

    initial begin
        int                ack_k[$];
        int                ack_p[$];
        int                idle_k, en_cnt, errs, aborted, port;
        logic              rw;
        logic [ADDR_W-1:0] a, a0, a1;
        logic [DATA_W-1:0] d;

        rst = 1'b1;
        req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
        sram[32'h12345]    = 16'hBEEF;
        ref_mem[32'h12345] = 16'hBEEF;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd1);
        check("rst_en",    32'(mem_en), 32'd0);
        check("rst_rw",    32'(mem_rw), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_ack0",  32'(ack0), 32'd0);
        check("rst_ack1",  32'(ack1), 32'd0);
        check("rst_err0",  32'(err0), 32'd0);
        check("rst_err1",  32'(err1), 32'd0);
        check("rst_rd0",   32'(rdata0), 32'd0);
        check("rst_rd1",   32'(rdata1), 32'd0);

        // Both ports requesting continuously from the end of reset: grants alternate 0,1,0,1
        a0 = 19'($urandom);
        a1 = 19'($urandom);
        req0 = 1'b1; rw0 = 1'b0; addr0 = a0; wdata0 = 16'($urandom);
        req1 = 1'b1; rw1 = 1'b0; addr1 = a1; wdata1 = 16'($urandom);
        rst = 1'b0;
        idle_k = 0; en_cnt = 0; errs = 0;
        for (int k = 1; k <= FLUSH + 31; k++) begin
            @(negedge clk);
            if (busy === 1'b0 && idle_k == 0) idle_k = k;
            if (mem_en === 1'b1) en_cnt++;
            if (ack0 === 1'b1) begin ack_p.push_back(0); ack_k.push_back(k); end
            if (ack1 === 1'b1) begin ack_p.push_back(1); ack_k.push_back(k); end
            if (err0 === 1'b1 || err1 === 1'b1) errs++;
            if (k == FLUSH + 31) begin req0 = 1'b0; req1 = 1'b0; end
        end
        exp_rdata[0] = ref_rd(a0);
        exp_rdata[1] = ref_rd(a1);
        check("flush_len", 32'(idle_k), 32'(FLUSH));
        check("rr_nacks",  32'(ack_k.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_port%0d", i), (i < ack_p.size()) ? 32'(ack_p[i]) : 32'hFFFF_FFFF, 32'(i % 2));
            check($sformatf("rr_cyc%0d", i),  (i < ack_k.size()) ? 32'(ack_k[i]) : 32'hFFFF_FFFF,
                  32'(FLUSH + 7 + 8 * i));
        end
        check("rr_en",   32'(en_cnt), 32'd4);
        check("rr_errs", 32'(errs), 32'd0);
        check("rr_rd0",  32'(rdata0), 32'(exp_rdata[0]));
        check("rr_rd1",  32'(rdata1), 32'(exp_rdata[1]));

        // Directed single accesses
        do_access(0, 1'b0, 19'h12345, 16'h1111, 1'b0, "rd_p0");
        check("rd_p0_beef", 32'(rdata0), 32'hBEEF);
        do_access(1, 1'b1, 19'h7FFFF, 16'hA5A5, 1'b0, "wr_p1");
        do_access(1, 1'b0, 19'h7FFFF, 16'h0000, 1'b0, "rb_p1");
        check("rb_p1_a5a5", 32'(rdata1), 32'hA5A5);

        // Randomized accesses, with a small address pool so writes get read back
        for (int i = 0; i < 10; i++) begin
            port = int'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 1) == 0) ? 19'($urandom_range(0, 7)) : 19'($urandom);
            d    = 16'($urandom);
            do_access(port, rw, a, d, 1'b0, $sformatf("rnd%0d", i));
        end

        // Finish never arrives: watchdog error, then normal service resumes
        suppress = 1'b1;
        do_access(0, 1'b0, 19'($urandom), 16'($urandom), 1'b1, "tmo");
        suppress = 1'b0;
        do_access(0, 1'b0, 19'h12345, 16'h2222, 1'b0, "post_tmo");

        // Wrong-direction strobe during a read is ignored
        inject_wrong = 1'b1;
        do_access(1, 1'b0, 19'h7FFFF, 16'h3333, 1'b0, "wrong_stb");
        inject_wrong = 1'b0;

        // Reset during controller BEGIN phase
        @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        req1 = 1'b1; rw1 = 1'b0; addr1 = 19'h7FFFF; wdata1 = 16'h4444;
        aborted = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1 || err0 === 1'b1 || err1 === 1'b1) aborted++;
            if (k == 3) begin rst = 1'b1; req1 = 1'b0; end
        end
        @(negedge clk);
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_en",   32'(mem_en), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_rd0",  32'(rdata0), 32'd0);
        check("abort_rd1",  32'(rdata1), 32'd0);
        rst = 1'b0;
        idle_k = 0;
        for (int k = 1; k <= FLUSH + 10; k++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1 || err0 === 1'b1 || err1 === 1'b1) aborted++;
            if (busy === 1'b0) begin
                idle_k = k;
                break;
            end
        end
        check("abort_flush", 32'(idle_k), 32'(FLUSH));
        check("abort_noack", 32'(aborted), 32'd0);
        do_access(1, 1'b0, 19'h12345, 16'h5555, 1'b0, "post_rst");
        check("post_rst_beef", 32'(rdata1), 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
